image_bank_reader: RTL

Read-side sequencer for the four banked image RAMs (14-bit address, 8-bit data, one-cycle read latency) that the host loader fills four bytes per write. On a start pulse it walks a contiguous address range and streams each address's four bank bytes, repacked into one 32-bit word, to the convolution engine over a valid/ready interface. A small output FIFO absorbs the RAM read latency so the stream runs at one word per cycle under no backpressure and loses nothing under backpressure.

---
 rtl/image_bank_reader_if.sv | 31 +++
 rtl/image_bank_reader.sv | 112 +++++++++++
 2 files changed

// File: rtl/image_bank_reader_if.sv
// Bundle of the reader's control, image-RAM and stream signals.
// master = the reader; slave = host/RAM/consumer side.
interface image_bank_reader_if #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rden;
  logic [7:0]        ram_q0;
  logic [7:0]        ram_q1;
  logic [7:0]        ram_q2;
  logic [7:0]        ram_q3;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start, base_addr, len, ram_q0, ram_q1, ram_q2, ram_q3, out_ready,
    output busy, done, ram_addr, ram_rden, out_data, out_valid
  );

  modport slave (
    output start, base_addr, len, ram_q0, ram_q1, ram_q2, ram_q3, out_ready,
    input  busy, done, ram_addr, ram_rden, out_data, out_valid
  );
endinterface

// File: rtl/image_bank_reader.sv
// Walks a contiguous image-RAM range and streams the four bank bytes of each
// address as one 32-bit word, with a small FIFO hiding the one-cycle read latency.
module image_bank_reader #(
  parameter int ADDR_W     = 14,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  image_bank_reader_if.master  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              inflight_q;
  logic              done_q, done_d;
  logic              issue, push, pop, empty;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW:0]       used;

  assign push  = inflight_q;
  assign empty = (cnt_q == '0);
  assign pop   = !empty && bus.out_ready;
  // Words already in the FIFO plus the read whose data lands next cycle.
  assign used  = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d = bus.base_addr;
          rem_d  = bus.len;
          if (bus.len != '0) state_d = RUN;
          else               done_d  = 1'b1;
        end
      end
      RUN: begin
        if (used < DEPTH_C) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // No issues here, so cnt_d == 0 also means nothing is in flight.
        if (cnt_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= issue;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      if (push) wr_q <= (wr_q == LAST_P) ? '0 : wr_q + 1'b1;
      if (pop)  rd_q <= (rd_q == LAST_P) ? '0 : rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {bus.ram_q0, bus.ram_q1, bus.ram_q2, bus.ram_q3};
  end

  assign bus.ram_rden  = issue;
  assign bus.ram_addr  = addr_q;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 32'h0 : mem_q[rd_q];
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && cnt_q == CW'(FIFO_DEPTH)))
    else $error("image_bank_reader: push into full FIFO");
endmodule
